// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Fetch stage with a direct-mapped, single-word-line I-cache and
//               a blocking miss handler toward the memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter int ICACHE_LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  stall_signal,
    input  logic        jump_flag,
    input  logic [31:0] jump_addr,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        stall_req_o
);

    localparam int c_IDX_W = $clog2(ICACHE_LINES);
    localparam int c_TAG_W = 32 - c_IDX_W - 2;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [31:0]               r_pc;
    logic [31:0]               r_req_addr;
    logic [ICACHE_LINES-1:0]   r_valid;
    logic [c_TAG_W-1:0]        r_tag  [ICACHE_LINES];
    logic [31:0]               r_data [ICACHE_LINES];

    logic [c_IDX_W-1:0]        w_idx;
    logic [c_TAG_W-1:0]        w_tag;
    logic [c_IDX_W-1:0]        w_fill_idx;
    logic [c_TAG_W-1:0]        w_fill_tag;
    logic                      w_hit;
    logic                      w_start;
    logic                      w_fill;
    logic                      w_unused;

    assign w_idx      = r_pc[c_IDX_W+1:2];
    assign w_tag      = r_pc[31:c_IDX_W+2];
    assign w_fill_idx = r_req_addr[c_IDX_W+1:2];
    assign w_fill_tag = r_req_addr[31:c_IDX_W+2];
    assign w_unused   = ^{stall_signal[4:1], jump_addr[1:0]};

    assign w_hit = (r_state == S_IDLE) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    // Next-state logic; a jump on a miss cycle suppresses the request since the
    // missed address is no longer wanted.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_fill      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_hit && !jump_flag) begin
                    w_state_nxt = S_WAIT;
                    w_start     = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_ready_i) begin
                    w_state_nxt = S_IDLE;
                    w_fill      = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= 32'h0;
            r_req_addr <= 32'h0;
            r_valid    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (jump_flag) begin
                r_pc <= {jump_addr[31:2], 2'b00};
            end else if (w_hit && !stall_signal[0]) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_start) begin
                r_req_addr <= r_pc;
            end
            if (w_fill) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage is qualified by the valid bits, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= mem_data_i;
        end
    end

    assign pc_o        = w_hit ? r_pc : 32'h0;
    assign inst_o      = w_hit ? r_data[w_idx] : 32'h0;
    assign stall_req_o = !w_hit;
    assign mem_req_o   = (r_state == S_WAIT);
    assign mem_addr_o  = (r_state == S_WAIT) ? r_req_addr : 32'h0;

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with the following parameter and ports (name, direction/default, width, meaning):
- ICACHE_LINES, default 16, number of direct-mapped I-cache lines; power of two, minimum 2.
- clk, in, 1, rising-edge clock.
- rst, in, 1, synchronous active-high reset.
- stall_signal, in, 5, pipeline stall vector; only bit 0 (fetch-stage hold) is used.
- jump_flag, in, 1, redirect request from the execute stage.
- jump_addr, in, 32, redirect target.
- mem_req_o, out, 1, instruction word request to the memory controller.
- mem_addr_o, out, 32, word-aligned request address.
- mem_ready_i, in, 1, memory controller response strobe, one cycle wide.
- mem_data_i, in, 32, returned instruction word; valid only when mem_ready_i=1.
- pc_o, out, 32, PC of the presented instruction; feeds the IF/ID register.
- inst_o, out, 32, presented instruction word; feeds the IF/ID register.
- stall_req_o, out, 1, request to the stall controller that no valid instruction is available.

Function
REQ-002 Internal state SHALL be: PC register, state FSM {IDLE, WAIT}, req_addr register, and per-line valid bit, tag and data.
REQ-003 Cache index SHALL be pc[log2(ICACHE_LINES)+1:2]; the tag SHALL be the remaining upper PC bits; pc[1:0] SHALL always be 0.
REQ-004 The cache lookup SHALL be combinational. In IDLE, a hit SHALL be: valid[index]=1 and tag[index] equals the PC tag.
REQ-005 In IDLE on a hit, outputs SHALL be pc_o=PC, inst_o=line data, stall_req_o=0, all in the same cycle.
REQ-006 In IDLE on a miss, or in any WAIT cycle, outputs SHALL be pc_o=0, inst_o=0, stall_req_o=1.
REQ-007 PC update at the clock edge SHALL follow this priority:
- rst: PC=0.
- else jump_flag=1: PC={jump_addr[31:2],2'b00}.
- else stall_signal[0]=1, or no hit this cycle: PC holds.
- else: PC=PC+4, with modulo-2^32 wrap (0xFFFFFFFC -> 0x00000000).
REQ-008 Transition IDLE -> WAIT: on a miss when jump_flag=0, req_addr SHALL capture PC.
REQ-009 If jump_flag=1 in an IDLE miss cycle, the FSM SHALL stay IDLE and issue no request.
REQ-010 In WAIT, mem_req_o SHALL be 1 and mem_addr_o SHALL be req_addr.
REQ-011 In IDLE, mem_req_o SHALL be 0 and mem_addr_o SHALL be 0. Miss-to-request latency SHALL be exactly 1 cycle.
REQ-012 Once raised, mem_req_o SHALL NOT be retracted and mem_addr_o SHALL NOT change until mem_ready_i=1, regardless of jump_flag or stall_signal.
REQ-013 WAIT with mem_ready_i=1 SHALL write mem_data_i into line req_addr-index, set that line's tag and valid, and return to IDLE.
REQ-014 A jump while in WAIT SHALL update the PC only; the outstanding response SHALL still be written to the cache and SHALL NOT be presented unless the new PC hits it.
REQ-015 mem_ready_i in IDLE SHALL be ignored.
REQ-016 The first cycle after a fill, a lookup SHALL be made at the current PC. A fill to the same line as the PC SHALL hit. Minimum miss penalty SHALL be memory latency + 2 cycles.
REQ-017 stall_signal[0]=1 SHALL hold the PC and outputs but SHALL NOT block the IDLE->WAIT transition or a fill.
REQ-018 A fill SHALL overwrite any prior line contents. There SHALL be no self-modifying-code coherence.

Reset
REQ-019 While rst=1 at a clock edge, the block SHALL set PC=0, clear all valid bits, set state=IDLE and set req_addr=0.
REQ-020 In the cycle after reset, outputs SHALL be mem_req_o=0, stall_req_o=1, pc_o=0, inst_o=0.
REQ-021 Reset asserted during WAIT SHALL abandon the request, with mem_req_o=0 the next cycle. The memory controller shares rst.
REQ-022 Tag and data arrays SHALL need no reset.

Verification
REQ-023 Cold start: release rst; memory returns 0x00000013 after 3 cycles.
- Cycle 1: mem_req_o=1, mem_addr_o=0.
- After ready plus 1 cycle: pc_o=0, inst_o=0x00000013, stall_req_o=0.
REQ-024 Sequential hits: preload lines for 0x0, 0x4, 0x8 and hold stall_signal=0 -> pc_o is 0x0, 0x4, 0x8 on consecutive cycles, with stall_req_o=0 throughout.
REQ-025 Stall: stall_signal=5'b00001 for 2 cycles during hits at PC=0x4 -> pc_o stays 0x4 for those 2 cycles, then advances to 0x8.
REQ-026 Jump during WAIT: request outstanding for 0x10; pulse jump_flag with jump_addr=0x40 -> mem_addr_o stays 0x10 until ready. Then line 0x10 is valid, and the next request is 0x40.
REQ-027 Misaligned jump and aliasing:
- jump_addr=0x47 -> PC=0x44.
- With 16 lines, 0x0 and 0x40 alias the same line; after filling 0x40, a fetch at 0x0 misses and reissues.
REQ-028 Reset mid-WAIT: assert rst while mem_req_o=1 -> mem_req_o=0 and PC=0 the next cycle, and all lines are invalid (the next fetch at 0x0 misses).
